// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter:
//   - arb_state_e : FSM state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits)
//   - arb_gnt_e   : grant owner codes (GNT_I = I-cache, GNT_D = D-cache)
//   - default geometry and watchdog depth
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W_DEF   = 16;
  localparam int ARB_DATA_W_DEF   = 16;
  localparam int ARB_MAX_WAIT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// -----------------------------------------------------------------------------
// mem_arb_timeout
// Watchdog counter for the arbiter WAIT state. The count is cleared by clr,
// advances by one on each en cycle, and expire is high while the count equals
// MAX_WAIT-1. expire is registered from the next-count value, so it lines up
// exactly with the count register.
// Ports:
//   clk    in  clock
//   rst    in  synchronous reset, active-high
//   clr    in  clear count to zero (wins over en)
//   en     in  advance count by one
//   expire out count has reached MAX_WAIT-1
// -----------------------------------------------------------------------------
module mem_arb_timeout
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             expire_r;

  // Next count: clear has priority, otherwise step when enabled.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (en) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register and registered expire flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      expire_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      expire_r <= (cnt_nxt_s == CNT_LAST);
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single main-memory port between I-cache and D-cache miss traffic.
// One access in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : pick a winner among live requests, latch its address/wr/wdata.
//   ISSUE: mem_en high for this single cycle; watchdog cleared.
//   WAIT : wait for mem_done; a watchdog expiry ends the access with data 0
//          and sets the sticky err flag (mem_done in the same cycle wins).
//   RESP : one-cycle ack to the winner with registered read data.
// Configuration macro MEM_ARB_RR_EN:
//   undefined -> fixed priority, D-cache wins simultaneous requests.
//   defined   -> round-robin, simultaneous requests go to the side not granted
//                last; the pointer only moves on a grant.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             I-cache read request (level, held until i_ack)
//   i_ack/i_rdata            I-cache completion pulse and read data
//   d_req/d_wr/d_addr/d_wdata D-cache request (level, held until d_ack)
//   d_ack/d_rdata            D-cache completion pulse and data (0 for writes)
//   mem_en/mem_wr            one-cycle memory strobe and write qualifier
//   mem_addr/mem_wdata       registered access address and write data
//   mem_rdata/mem_done       memory read data and completion pulse
//   busy                     high in any state other than IDLE
//   err                      sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W_DEF,
  parameter int DATA_W   = ARB_DATA_W_DEF,
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              err
);

  arb_state_e        state_r,     state_nxt_s;
  arb_gnt_e          gnt_r,       gnt_nxt_s;
  arb_gnt_e          win_s;
  logic              wr_r,        wr_nxt_s;
  logic [ADDR_W-1:0] addr_r,      addr_nxt_s;
  logic [DATA_W-1:0] wdata_r,     wdata_nxt_s;
  logic              mem_en_r,    mem_en_nxt_s;
  logic              mem_wr_r,    mem_wr_nxt_s;
  logic              i_ack_r,     i_ack_nxt_s;
  logic              d_ack_r,     d_ack_nxt_s;
  logic [DATA_W-1:0] i_rdata_r,   i_rdata_nxt_s;
  logic [DATA_W-1:0] d_rdata_r,   d_rdata_nxt_s;
  logic              err_r,       err_nxt_s;
  logic              busy_r;
  logic [DATA_W-1:0] resp_data_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              expire_s;
  logic              any_req_s;

  assign any_req_s = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // Side granted most recently; reset value makes the first tie go to D.
  arb_gnt_e rr_last_r;

  // Round-robin pick: on a tie, grant the side that was not granted last.
  always_comb begin
    win_s = GNT_I;
    if (i_req && d_req) begin
      if (rr_last_r == GNT_I) begin
        win_s = GNT_D;
      end else begin
        win_s = GNT_I;
      end
    end else if (d_req) begin
      win_s = GNT_D;
    end else begin
      win_s = GNT_I;
    end
  end

  // Round-robin pointer moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r <= GNT_I;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      rr_last_r <= win_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`else
  // Fixed-priority pick: D-cache beats I-cache.
  always_comb begin
    win_s = GNT_I;
    if (d_req) begin
      win_s = GNT_D;
    end else begin
      win_s = GNT_I;
    end
  end
`endif

  // Writes return zero data; reads return what memory delivered.
  always_comb begin
    resp_data_s = {DATA_W{1'b0}};
    if (wr_r) begin
      resp_data_s = {DATA_W{1'b0}};
    end else begin
      resp_data_s = mem_rdata;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    wr_nxt_s      = wr_r;
    addr_nxt_s    = addr_r;
    wdata_nxt_s   = wdata_r;
    mem_en_nxt_s  = 1'b0;
    mem_wr_nxt_s  = 1'b0;
    i_ack_nxt_s   = 1'b0;
    d_ack_nxt_s   = 1'b0;
    i_rdata_nxt_s = {DATA_W{1'b0}};
    d_rdata_nxt_s = {DATA_W{1'b0}};
    err_nxt_s     = err_r;
    cnt_clr_s     = 1'b0;
    cnt_en_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt_nxt_s    = win_s;
          mem_en_nxt_s = 1'b1;
          state_nxt_s  = ST_ISSUE;
          if (win_s == GNT_D) begin
            wr_nxt_s     = d_wr;
            addr_nxt_s   = d_addr;
            mem_wr_nxt_s = d_wr;
            if (d_wr) begin
              wdata_nxt_s = d_wdata;
            end else begin
              wdata_nxt_s = {DATA_W{1'b0}};
            end
          end else begin
            wr_nxt_s     = 1'b0;
            addr_nxt_s   = i_addr;
            mem_wr_nxt_s = 1'b0;
            wdata_nxt_s  = {DATA_W{1'b0}};
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // mem_en is high during this cycle from the registered strobe.
        cnt_clr_s   = 1'b1;
        state_nxt_s = ST_WAIT;
      end

      ST_WAIT: begin
        // Completion takes precedence over a simultaneous expiry.
        if (mem_done) begin
          state_nxt_s = ST_RESP;
          if (gnt_r == GNT_D) begin
            d_ack_nxt_s   = 1'b1;
            d_rdata_nxt_s = resp_data_s;
          end else begin
            i_ack_nxt_s   = 1'b1;
            i_rdata_nxt_s = resp_data_s;
          end
        end else if (expire_s) begin
          state_nxt_s = ST_RESP;
          err_nxt_s   = 1'b1;
          if (gnt_r == GNT_D) begin
            d_ack_nxt_s = 1'b1;
          end else begin
            i_ack_nxt_s = 1'b1;
          end
        end else begin
          cnt_en_s    = 1'b1;
          state_nxt_s = ST_WAIT;
        end
      end

      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt_r     <= GNT_I;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      mem_en_r  <= 1'b0;
      mem_wr_r  <= 1'b0;
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      i_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gnt_r     <= gnt_nxt_s;
      wr_r      <= wr_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      mem_en_r  <= mem_en_nxt_s;
      mem_wr_r  <= mem_wr_nxt_s;
      i_ack_r   <= i_ack_nxt_s;
      d_ack_r   <= d_ack_nxt_s;
      i_rdata_r <= i_rdata_nxt_s;
      d_rdata_r <= d_rdata_nxt_s;
      err_r     <= err_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  mem_arb_timeout #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .expire (expire_s)
  );

  assign i_ack     = i_ack_r;
  assign i_rdata   = i_rdata_r;
  assign d_ack     = d_ack_r;
  assign d_rdata   = d_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule
